// File: rtl/dcache_req_ctrl_pkg.sv
// dcache_req_ctrl_pkg: shared FSM state encodings and access size codes for the data-cache request path.
package dcache_req_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/dcache_req_ctrl.sv
// dcache_req_ctrl: issues EX-stage requests to the data cache and filters responses cancelled by a flush.
// Define DCACHE_REQ_PIPELINE_EN to allow two outstanding requests instead of one.
module dcache_req_ctrl
  import dcache_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_req_valid,
  input  logic              es_req_wr,
  input  logic [1:0]        es_req_size,
  input  logic [3:0]        es_req_wstrb,
  input  logic [ADDR_W-1:0] es_req_addr,
  input  logic [31:0]       es_req_wdata,
  output logic              es_req_ready,
  output logic              dc_req,
  output logic              dc_wr,
  output logic [1:0]        dc_size,
  output logic [3:0]        dc_wstrb,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [31:0]       dc_wdata,
  input  logic              dc_addr_ok,
  input  logic              dc_data_ok,
  input  logic [31:0]       dc_rdata,
  input  logic              flush,
  output logic              ms_data_ok,
  output logic [31:0]       ms_rdata,
  output logic              busy,
  output logic              proto_err
);
`ifdef DCACHE_REQ_PIPELINE_EN
  localparam int MAX_OUT = 2;
  localparam int CW = 2;
`else
  localparam int MAX_OUT = 1;
  localparam int CW = 1;
`endif
  state_t state, state_nxt;
  logic [CW-1:0] outstanding, out_nxt, cancel_cnt, cancel_nxt;
  logic full, accept, dok;
  assign dc_wr = es_req_wr;
  assign dc_size = es_req_size;
  assign dc_wstrb = es_req_wstrb;
  assign dc_addr = es_req_addr;
  assign dc_wdata = es_req_wdata;
  assign full = outstanding == CW'(MAX_OUT);
  assign dc_req = es_req_valid & ~full & ~flush & (state != ST_DRAIN);
  assign accept = dc_req & dc_addr_ok;
  assign es_req_ready = accept;
  // a data_ok with nothing outstanding is a protocol error and never touches the counters
  assign dok = dc_data_ok & (outstanding != '0);
  assign ms_data_ok = dc_data_ok & ~flush & (state == ST_WAIT);
  assign ms_rdata = dc_rdata;
  assign busy = state != ST_IDLE;
  always_comb begin
    out_nxt = outstanding + CW'(accept) - CW'(dok);
    cancel_nxt = cancel_cnt;
    state_nxt = state;
    if (state == ST_DRAIN) begin
      cancel_nxt = cancel_cnt - CW'(dok);
      state_nxt = (cancel_nxt == '0) ? ST_IDLE : ST_DRAIN;
    end else if (flush) begin
      cancel_nxt = out_nxt;
      state_nxt = (out_nxt == '0) ? ST_IDLE : ST_DRAIN;
    end else begin
      state_nxt = (out_nxt == '0) ? ST_IDLE : ST_WAIT;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      outstanding <= '0;
      cancel_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      outstanding <= out_nxt;
      cancel_cnt <= cancel_nxt;
      proto_err <= proto_err | (dc_data_ok & (outstanding == '0));
    end
  end
endmodule
